// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32I pipeline: operand
// forwarding, load-use and memory stalls, branch flushes and a debug halt drain.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal execution; hazards resolved by stall/flush/forward
// DRAIN   | halt requested; fetch discarded while the D-stage instruction retires
// HALTED  | pipeline empty and quiescent; resumes when HaltReq drops
module hazard_ctrl #(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             DMemReqM,
    input  logic             DMemAckM,
    input  logic             HaltReq,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCycles
);

    // Data width only matters to neighbouring stages; reject nonsensical values.
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("hazard_ctrl: unsupported XLEN");
    end

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_DRAIN  = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    localparam logic [1:0]       DRAIN_LOAD = 2'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic mem_stall;
    logic lw_stall;
    logic load_in_e;
    logic drain_advance;

    // Hazard detection. A taken branch kills the D instruction, so it masks the load-use stall.
    always_comb begin
        mem_stall = DMemReqM & ~DMemAckM;
        load_in_e = (ResultSrcE == 2'b01) && (RdE != 5'd0);
        lw_stall  = load_in_e && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
    end

    // Forwarding: the younger result in M takes precedence over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end
        end
    end

    // Stall/flush outputs; a memory stall freezes everything, including a pending branch flush.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        Halted = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            Halted = (state_q == S_HALTED);
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                unique case (state_q)
                    S_RUN: begin
                        StallF = lw_stall;
                        StallD = lw_stall;
                        FlushD = PCSrcE;
                        FlushE = lw_stall | PCSrcE;
                    end
                    S_DRAIN: begin
                        StallF = ~PCSrcE;
                        StallD = lw_stall;
                        FlushD = 1'b1;
                        FlushE = lw_stall | PCSrcE;
                    end
                    S_HALTED: begin
                        StallF = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end
                    default: begin
                        StallF = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end
                endcase
            end
        end
    end

    // Next state, drain counter and stall-cycle counter.
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        stall_cycles_d = stall_cycles_q;
        drain_advance  = !mem_stall && !lw_stall && (drain_cnt_q != 2'd0);

        if ((state_q == S_RUN) && (StallF || StallM) && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end

        unique case (state_q)
            S_RUN: begin
                if (HaltReq && !mem_stall) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_advance) begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
                if (!mem_stall && (drain_cnt_d == 2'd0)) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!HaltReq) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d     = S_RUN;
                drain_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RUN;
            drain_cnt_q    <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle halt and
// saturation sequences, and random stimulus against a behavioural pipeline model.
module tb_hazard_ctrl;

    localparam int CNT_W     = 4;
    localparam int DRAIN_CYC = 3;
    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_HALTED  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, RegWriteM, RegWriteW, DMemReqM, DMemAckM, HaltReq;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Halted;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCycles;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.XLEN(32), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .DMemReqM(DMemReqM), .DMemAckM(DMemAckM), .HaltReq(HaltReq),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Halted(Halted), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        logic       halted;
    } exp_t;

    int               m_mode = M_RUN;
    int               m_left = 0;
    logic [CNT_W-1:0] m_cnt  = '0;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic mem_busy();
        return DMemReqM && !DMemAckM;
    endfunction

    function automatic logic load_use();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (rst) begin
            e.fd = 1; e.fe = 1; e.fw = 1;
            return e;
        end
        e.fa     = fwd_sel(Rs1E);
        e.fb     = fwd_sel(Rs2E);
        e.halted = (m_mode == M_HALTED);
        if (mem_busy()) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else if (m_mode == M_RUN) begin
            e.sf = load_use(); e.sd = load_use();
            e.fd = PCSrcE;     e.fe = load_use() | PCSrcE;
        end else if (m_mode == M_DRAIN) begin
            e.sf = !PCSrcE;    e.sd = load_use();
            e.fd = 1;          e.fe = load_use() | PCSrcE;
        end else begin
            e.sf = 1; e.fd = 1; e.fe = 1;
        end
        return e;
    endfunction

    task automatic model_update();
        exp_t e;
        e = model_out();
        if (rst) begin
            m_mode = M_RUN; m_left = 0; m_cnt = '0;
            return;
        end
        if (m_mode == M_RUN && (e.sf || e.sm) && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        case (m_mode)
            M_RUN: if (HaltReq && !mem_busy()) begin
                m_mode = M_DRAIN; m_left = DRAIN_CYC;
            end
            M_DRAIN: begin
                // each cycle free of memory and load-use stalls brings retirement one step closer
                if (!mem_busy() && !load_use() && m_left > 0) m_left = m_left - 1;
                if (!mem_busy() && m_left == 0) m_mode = M_HALTED;
            end
            default: if (!HaltReq) m_mode = M_RUN;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t e;
        e = model_out();
        chk({tag, ".StallF"}, 32'(StallF), 32'(e.sf));
        chk({tag, ".StallD"}, 32'(StallD), 32'(e.sd));
        chk({tag, ".StallE"}, 32'(StallE), 32'(e.se));
        chk({tag, ".StallM"}, 32'(StallM), 32'(e.sm));
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(e.fd));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(e.fe));
        chk({tag, ".FlushW"}, 32'(FlushW), 32'(e.fw));
        chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(e.fa));
        chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(e.fb));
        chk({tag, ".Halted"}, 32'(Halted), 32'(e.halted));
        chk({tag, ".StallCycles"}, 32'(StallCycles), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        DMemReqM = 0; DMemAckM = 0;
    endtask

    task automatic do_reset();
        rst = 1; set_idle(); HaltReq = 0;
        RdM = 5'd9; RegWriteM = 1; Rs1E = 5'd9;
        #1;
        chk("rst.FlushD", 32'(FlushD), 1);
        chk("rst.FlushW", 32'(FlushW), 1);
        chk("rst.StallF", 32'(StallF), 0);
        chk("rst.ForwardAE", 32'(ForwardAE), 0);
        check_all("rst");
        tick();
        tick();
        rst = 0; set_idle();
        #1;
        chk("rst.StallCycles", 32'(StallCycles), 0);
        chk("rst.Halted", 32'(Halted), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pc;
        logic [4:0] rdm, rdw;
        logic       rwm, rww, req, ack;
        logic [3:0] st;   // {StallF, StallD, StallE, StallM}
        logic [2:0] fl;   // {FlushD, FlushE, FlushW}
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n, found;
        logic [CNT_W-1:0] cnt0;

        vecs[0]  = '{0, 0, 5, 6, 0, 0, 0, 5, 6, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b10, 2'b01};
        vecs[1]  = '{0, 0, 5, 6, 0, 0, 0, 0, 6, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b01};
        vecs[2]  = '{0, 0, 7, 7, 0, 0, 0, 7, 7, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b10, 2'b10};
        vecs[3]  = '{0, 0, 7, 3, 0, 0, 0, 7, 7, 0, 1, 0, 0, 4'b0000, 3'b000, 2'b01, 2'b00};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[5]  = '{1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 3'b010, 2'b00, 2'b00};
        vecs[6]  = '{1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b110, 2'b00, 2'b00};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[8]  = '{5, 0, 0, 0, 5, 2, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 2'b00, 2'b00};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 4'b0000, 3'b110, 2'b00, 2'b00};
        vecs[11] = '{5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 3'b001, 2'b00, 2'b00};
        vecs[12] = '{9, 0, 3, 0, 9, 1, 0, 0, 3, 0, 1, 0, 0, 4'b1100, 3'b010, 2'b01, 2'b00};

        rst = 1; HaltReq = 0; set_idle();
        do_reset();

        foreach (vecs[i]) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pc;
            RdM = vecs[i].rdm; RdW = vecs[i].rdw; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            DMemReqM = vecs[i].req; DMemAckM = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d.stall", i), 32'({StallF, StallD, StallE, StallM}), 32'(vecs[i].st));
            chk($sformatf("vec%0d.flush", i), 32'({FlushD, FlushE, FlushW}), 32'(vecs[i].fl));
            chk($sformatf("vec%0d.ForwardAE", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("vec%0d.ForwardBE", i), 32'(ForwardBE), 32'(vecs[i].fb));
            tick();
        end

        // frozen branch: four memory-stall cycles, then the flush goes through
        do_reset();
        cnt0 = StallCycles;
        for (int k = 0; k < 4; k++) begin
            DMemReqM = 1; DMemAckM = 0; PCSrcE = 1;
            #1;
            chk("memstall.stall", 32'({StallF, StallD, StallE, StallM}), 32'hF);
            chk("memstall.flush", 32'({FlushD, FlushE, FlushW}), 32'b001);
            check_all("memstall");
            tick();
        end
        DMemReqM = 0;
        #1;
        chk("memstall.release_flush", 32'({FlushD, FlushE, FlushW}), 32'b110);
        chk("memstall.release_StallF", 32'(StallF), 0);
        tick();
        PCSrcE = 0;
        #1;
        chk("memstall.count", 32'(StallCycles - cnt0), 4);

        // single-cycle halt pulse: three drain cycles, then halted for one cycle
        do_reset();
        HaltReq = 1;
        #1; check_all("halt.req");
        tick();
        HaltReq = 0;
        n = 0; found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            #1; check_all("halt.drain");
            if (Halted) found = 1;
            else begin
                if (FlushD && StallF) n++;
                tick();
            end
        end
        chk("halt.reached", 32'(found), 1);
        chk("halt.drain_cycles", 32'(n), 3);
        tick();
        #1;
        chk("halt.resume", 32'(Halted), 0);
        check_all("halt.resume");

        // drain stretched by a two-cycle memory stall, with a taken branch
        do_reset();
        HaltReq = 1;
        #1; tick();
        n = 0; found = 0;
        for (int k = 0; k < 14 && found == 0; k++) begin
            DMemReqM = (k < 2); DMemAckM = 0; PCSrcE = (k == 2);
            #1; check_all("drain2");
            if (Halted) found = 1;
            else begin
                n++;
                if (k == 2) chk("drain2.branch_StallF", 32'(StallF), 0);
                tick();
            end
        end
        chk("drain2.reached", 32'(found), 1);
        chk("drain2.cycles", 32'(n), 5);
        tick();
        HaltReq = 0;
        #1; chk("drain2.still_halted", 32'(Halted), 1);
        tick();
        #1;
        chk("drain2.resume_Halted", 32'(Halted), 0);
        chk("drain2.resume_StallF", 32'(StallF), 0);

        // counter saturation, then reset in the middle of a stalled drain
        do_reset();
        DMemReqM = 1; DMemAckM = 0;
        for (int k = 0; k < 20; k++) begin
            #1; check_all("sat");
            tick();
        end
        #1;
        chk("sat.value", 32'(StallCycles), 32'((1 << CNT_W) - 1));
        DMemReqM = 0; HaltReq = 1;
        #1; tick();
        DMemReqM = 1;
        #1; check_all("rstdrain.pre");
        tick();
        rst = 1; RdM = 5'd4; RegWriteM = 1; Rs1E = 5'd4;
        #1;
        chk("rstdrain.FlushD", 32'(FlushD), 1);
        chk("rstdrain.StallM", 32'(StallM), 0);
        chk("rstdrain.ForwardAE", 32'(ForwardAE), 0);
        tick();
        rst = 0; HaltReq = 0; set_idle();
        #1;
        chk("rstdrain.Halted", 32'(Halted), 0);
        chk("rstdrain.StallCycles", 32'(StallCycles), 0);
        chk("rstdrain.StallF", 32'(StallF), 0);
        check_all("rstdrain.post");
        tick();

        // random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) HaltReq = ~HaltReq;
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));  RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));  ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 5) == 0);
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            DMemReqM = ($urandom_range(0, 3) == 0); DMemAckM = 1'($urandom_range(0, 1));
            #1; check_all("rnd");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32I core. It drives the stall and flush inputs of every pipeline register, including StallD/FlushD of decode, and the E-stage operand forwarding selects. It also freezes the pipeline while data memory is busy, and runs a debug halt sequence that drains the pipeline to an empty, quiescent state. It includes a saturating stall-cycle performance counter.

## Interface
- XLEN, 32, data width (unused internally; kept for pipeline-uniform instantiation)
- CNT_W, 32, width of stall-cycle counter
- DRAIN_CYC, 3, non-stalled cycles needed for the D-stage instruction to retire

- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- Rs1D, Rs2D  input  5 each  source registers in D
- Rs1E, Rs2E, RdE  input  5 each  E-stage source and destination registers
- ResultSrcE  input  2  E-stage result select; 2'b01 = load
- PCSrcE  input  1  taken branch or jump resolved in E
- RdM, RdW  input  5 each  destination registers in M and W
- RegWriteM, RegWriteW  input  1 each  register write enables in M and W
- DMemReqM  input  1  data-memory access pending in M
- DMemAckM  input  1  data memory completes the access this cycle
- HaltReq  input  1  debug halt request (level)
- StallF, StallD, StallE, StallM  output  1 each  hold the PC and the IF/ID, ID/EX, EX/MEM registers
- FlushD, FlushE, FlushW  output  1 each  bubble the IF/ID, ID/EX, MEM/WB registers
- ForwardAE, ForwardBE  output  2 each  00 = RF, 01 = ResultW, 10 = ALUResultM
- Halted  output  1  pipeline empty and halted
- StallCycles  output  CNT_W  saturating stall-cycle count

## Operation
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M wins over W. ForwardBE is the same with Rs2E.
- lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE. A taken branch kills the D instruction, so it masks lwStall.
- MemStall = DMemReqM & ~DMemAckM.
- Priority, highest first:
  - MemStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A branch in E stays frozen; its flush waits until the stall ends.
  - Otherwise, in RUN: StallF=StallD=lwStall; FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
- FSM states RUN, DRAIN, HALTED. Registers: state, 2-bit drain counter, StallCycles.
  - RUN -> DRAIN when HaltReq=1 and MemStall=0. The drain counter loads DRAIN_CYC.
  - DRAIN:
    - FlushD=1 every cycle, so fetched instructions are discarded.
    - StallF=1 except in cycles with PCSrcE=1; the PC must capture the branch target.
    - lwStall handling as in RUN; the StallD it produces coexists with FlushD.
    - The counter decrements only in cycles with MemStall=0 and lwStall=0.
    - Counter==0 and MemStall=0 -> HALTED.
    - Deassertion of HaltReq during DRAIN does not abort the drain.
  - HALTED: StallF=1, FlushD=FlushE=1, Halted=1. HaltReq=0 -> RUN next cycle. The PC resumes from its held value.
- StallCycles increments by 1 on each RUN-state cycle where StallF|StallM=1. It holds at 2^CNT_W-1.

## Timing
- All hazard outputs are combinational from inputs and state. Stall/flush take effect at the next clk edge in the target registers.
- While rst=1:
  - StallF..StallM=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00, Halted=0.
  - The next state is RUN with counter 0 and StallCycles 0.
- Reset asserted in any state, including mid-drain or mid-MemStall, returns to RUN in one cycle.
- Halt latency:
  - HaltReq high at edge n with no stalls -> DRAIN from n+1; Halted=1 from n+1+DRAIN_CYC.
  - Each MemStall or lwStall cycle in DRAIN adds one cycle.
- Resume latency: HaltReq low while HALTED -> RUN and Halted=0 on the next cycle.
- DMemAckM in the same cycle as DMemReqM gives zero stall cycles.

## Test plan
- add x5 in M, sub x6 in W, E reads Rs1E=5, Rs2E=6 -> ForwardAE=10, ForwardBE=01. Same with RdM=0 -> ForwardAE=00.
- lw x5 in E, D uses Rs2D=5 -> one cycle of StallF=StallD=1 and FlushE=1, then no stall. Add PCSrcE=1 in that cycle -> StallD=0, FlushD=FlushE=1.
- DMemReqM=1 with DMemAckM low for 4 cycles while PCSrcE=1 -> 4 cycles of StallF..StallM=1, FlushW=1, FlushD=FlushE=0. Cycle 5 -> FlushD=FlushE=1. StallCycles advances by 4.
- HaltReq pulsed for 1 cycle in RUN, no hazards -> 3 DRAIN cycles with FlushD=1, then Halted=1. The register file shows the D-stage instruction retired; no later instruction writes.
- DRAIN with a 2-cycle MemStall plus a taken branch -> Halted after 5 cycles; the PC holds the branch target. HaltReq=0 -> RUN the next cycle and fetch from the target.
- Preload StallCycles near saturation, hold MemStall -> the counter stops at all-ones. Assert rst mid-DRAIN -> state RUN, StallCycles=0, Halted=0.
